// File: rtl/scr1_ahb_sram_slave.sv
// AHB-Lite responder that terminates one SCR1 core port on a
// single-port synchronous SRAM, with wait states and ERROR response.
module scr1_ahb_sram_slave #(
  parameter int unsigned MEM_AW      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0048_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hsel,
  input  logic [1:0]        htrans,
  input  logic [2:0]        hsize,
  input  logic              hwrite,
  input  logic [31:0]       haddr,
  input  logic [31:0]       hwdata,
  output logic              hready,
  output logic [31:0]       hrdata,
  output logic              hresp,
  output logic              ram_req,
  output logic              ram_we,
  output logic [MEM_AW-3:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DPH,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              write_q, write_d;
  logic              illegal;
  logic [3:0]        be;

  assign illegal = (hsize > 3'd2)
                || (hsize == 3'd1 && haddr[0])
                || (hsize == 3'd2 && haddr[1:0] != 2'b00)
                || (haddr[31:MEM_AW] != BASE_ADDR[31:MEM_AW]);

  always_comb begin
    be = 4'hF;
    unique case (1'b1)
      size_q == 2'd0: be = 4'b0001 << addr_q[1:0];
      size_q == 2'd1: be = 4'b0011 << {addr_q[1], 1'b0};
      default:        be = 4'hF;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    write_d   = write_q;
    hready    = 1'b1;
    hresp     = 1'b0;
    hrdata    = '0;
    ram_req   = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q[MEM_AW-1:2];
    ram_be    = '0;
    ram_wdata = '0;

    unique case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_DPH: begin
        if (cnt_q != 4'd0) begin
          hready = 1'b0;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          ram_req = 1'b1;
          ram_be  = be;
          if (write_q) begin
            ram_we    = 1'b1;
            ram_wdata = hwdata;
            state_d   = ST_IDLE;
          end else begin
            hready  = 1'b0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        hrdata  = ram_rdata;
        state_d = ST_IDLE;
      end
      ST_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        state_d = ST_ERR2;
      end
      ST_ERR2: begin
        hresp   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // every state that completes a beat may also take the next address
    if (hready && hsel && htrans[1]) begin
      addr_d  = haddr[MEM_AW-1:0];
      size_d  = hsize[1:0];
      write_d = hwrite;
      if (illegal) begin
        state_d = ST_ERR1;
      end else begin
        state_d = ST_DPH;
        cnt_d   = WS;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      write_q <= write_d;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_sram_slave.sv
// Bench for scr1_ahb_sram_slave: three instances with 0, 3 and 5
// wait states, each on its own SRAM model.
module tb_scr1_ahb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        hsel      [3];
  logic [1:0]  htrans    [3];
  logic [2:0]  hsize     [3];
  logic        hwrite    [3];
  logic [31:0] haddr     [3];
  logic [31:0] hwdata    [3];
  logic        hready    [3];
  logic [31:0] hrdata    [3];
  logic        hresp     [3];
  logic        ram_req   [3];
  logic        ram_we    [3];
  logic [13:0] ram_addr  [3];
  logic [3:0]  ram_be    [3];
  logic [31:0] ram_wdata [3];
  logic [31:0] ram_rdata [3];

  bit [31:0] mem [3][16384];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    scr1_ahb_sram_slave #(
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 5))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n[g]),
      .hsel     (hsel[g]),
      .htrans   (htrans[g]),
      .hsize    (hsize[g]),
      .hwrite   (hwrite[g]),
      .haddr    (haddr[g]),
      .hwdata   (hwdata[g]),
      .hready   (hready[g]),
      .hrdata   (hrdata[g]),
      .hresp    (hresp[g]),
      .ram_req  (ram_req[g]),
      .ram_we   (ram_we[g]),
      .ram_addr (ram_addr[g]),
      .ram_be   (ram_be[g]),
      .ram_wdata(ram_wdata[g]),
      .ram_rdata(ram_rdata[g])
    );
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (ram_req[g]) begin
        if (ram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[g][b])
              mem[g][ram_addr[g]][8*b +: 8] <= ram_wdata[g][8*b +: 8];
        end else begin
          ram_rdata[g] <= mem[g][ram_addr[g]];
        end
      end
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [2:0]  sz;
    logic        wr;
    logic [31:0] wd;
    logic        err;
    logic [3:0]  be;
    logic [31:0] rd;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        rsp;
    logic        rsp_w;
    int          waits;
    int          nreq;
    int          req_at;
    logic [3:0]  be;
    logic [13:0] ra;
    logic        we;
    logic [31:0] wdat;
    logic        done;
  } res_t;

  vec_t vecs [14];
  logic [7:0] mdl [int];

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endtask

  // one non-pipelined transfer; entered and left at posedge+1
  task automatic xfer(input int k, input logic [31:0] a,
                      input logic [2:0] sz, input logic wr,
                      input logic [31:0] wd, output res_t r);
    r = '{default: 0};
    hsel[k]   = 1'b1;
    htrans[k] = 2'd2;
    haddr[k]  = a;
    hsize[k]  = sz;
    hwrite[k] = wr;
    @(posedge clk); #1;
    hsel[k]   = 1'b0;
    htrans[k] = 2'd0;
    hwdata[k] = wd;
    for (int c = 0; c < 40 && !r.done; c++) begin
      @(negedge clk);
      if (ram_req[k]) begin
        r.nreq++;
        r.req_at = r.waits + 1;
        r.be     = ram_be[k];
        r.ra     = ram_addr[k];
        r.we     = ram_we[k];
        r.wdat   = ram_wdata[k];
      end
      if (hready[k]) begin
        r.done = 1'b1;
        r.rd   = hrdata[k];
        r.rsp  = hresp[k];
      end else begin
        r.waits++;
        r.rsp_w = r.rsp_w | hresp[k];
      end
      @(posedge clk); #1;
    end
    if (!r.done) chk("timeout", 0, 1);
  endtask

  task automatic idle_cyc(input int k);
    int kind;
    kind      = $urandom_range(0, 2);
    hsel[k]   = (kind != 0);
    htrans[k] = (kind == 0) ? 2'd2 : ((kind == 1) ? 2'd0 : 2'd1);
    haddr[k]  = $urandom;
    hwrite[k] = 1'($urandom);
    @(negedge clk);
    chk("noop_rdy", hready[k], 1);
    chk("noop_rsp", hresp[k], 0);
    chk("noop_req", ram_req[k], 0);
    chk("noop_hrdata", hrdata[k], 0);
    @(posedge clk); #1;
    hsel[k]   = 1'b0;
    htrans[k] = 2'd0;
  endtask

  function automatic logic is_err(logic [31:0] a, logic [2:0] sz);
    return (sz > 3'd2) || (sz == 3'd1 && a[0])
        || (sz == 3'd2 && a[1:0] != 2'b00)
        || (a[31:16] != 16'h0048);
  endfunction

  initial begin
    res_t r;
    int   ws;
    int   nb;
    logic [31:0] a, wd, ba, wa, exp_rd;
    logic [2:0]  sz;
    logic        wr, e;
    logic [3:0]  exp_be;

    for (int k = 0; k < 3; k++) begin
      rst_n[k]  = 1'b0;
      hsel[k]   = 1'b0;
      htrans[k] = 2'd0;
      hsize[k]  = 3'd0;
      hwrite[k] = 1'b0;
      haddr[k]  = '0;
      hwdata[k] = '0;
    end

    vecs[0]  = '{32'h0048_0010, 3'd2, 1, 32'hDEADBEEF, 0, 4'hF, 0};
    vecs[1]  = '{32'h0048_0010, 3'd2, 0, 0, 0, 4'hF, 32'hDEADBEEF};
    vecs[2]  = '{32'h0048_0003, 3'd0, 1, 32'h5500_0000, 0, 4'h8, 0};
    vecs[3]  = '{32'h0048_0002, 3'd1, 1, 32'h1234_0000, 0, 4'hC, 0};
    vecs[4]  = '{32'h0048_0000, 3'd2, 0, 0, 0, 4'hF, 32'h1234_0000};
    vecs[5]  = '{32'h0048_0002, 3'd2, 0, 0, 1, 4'h0, 0};
    vecs[6]  = '{32'h0049_0000, 3'd2, 0, 0, 1, 4'h0, 0};
    vecs[7]  = '{32'h0048_0001, 3'd1, 1, 32'h1, 1, 4'h0, 0};
    vecs[8]  = '{32'h0048_0000, 3'd3, 0, 0, 1, 4'h0, 0};
    vecs[9]  = '{32'h0048_0011, 3'd0, 1, 32'h0000_AA00, 0, 4'h2, 0};
    vecs[10] = '{32'h0048_0010, 3'd2, 0, 0, 0, 4'hF, 32'hDEADAAEF};
    vecs[11] = '{32'h0048_0012, 3'd1, 0, 0, 0, 4'hC, 32'hDEADAAEF};
    vecs[12] = '{32'h0047_FFFC, 3'd2, 0, 0, 1, 4'h0, 0};
    vecs[13] = '{32'h0048_0001, 3'd0, 0, 0, 0, 4'h2, 32'h1234_0000};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hready", hready[0], 1);
    chk("rst_hresp", hresp[0], 0);
    chk("rst_hrdata", hrdata[0], 0);
    chk("rst_req", ram_req[0], 0);
    chk("rst_we", ram_we[0], 0);
    chk("rst_be", ram_be[0], 0);
    chk("rst_hready2", hready[2], 1);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      xfer(0, vecs[i].a, vecs[i].sz, vecs[i].wr, vecs[i].wd, r);
      chk($sformatf("v%0d_rsp", i), r.rsp, vecs[i].err);
      chk($sformatf("v%0d_waits", i), r.waits,
          (vecs[i].err || !vecs[i].wr) ? 1 : 0);
      chk($sformatf("v%0d_nreq", i), r.nreq, vecs[i].err ? 0 : 1);
      if (vecs[i].err) begin
        chk($sformatf("v%0d_err1", i), r.rsp_w, 1);
      end else begin
        chk($sformatf("v%0d_be", i), r.be, vecs[i].be);
        chk($sformatf("v%0d_addr", i), r.ra, vecs[i].a[15:2]);
        chk($sformatf("v%0d_we", i), r.we, vecs[i].wr);
        if (vecs[i].wr)
          chk($sformatf("v%0d_wdata", i), r.wdat, vecs[i].wd);
        else
          chk($sformatf("v%0d_rdata", i), r.rd, vecs[i].rd);
      end
    end

    hsel[0]   = 1'b1;
    htrans[0] = 2'd2;
    haddr[0]  = 32'h0048_0020;
    hsize[0]  = 3'd2;
    hwrite[0] = 1'b1;
    @(negedge clk);
    chk("b2b_aph_rdy", hready[0], 1);
    @(posedge clk); #1;
    hwdata[0] = 32'hCAFEF00D;
    htrans[0] = 2'd3;
    hwrite[0] = 1'b0;
    @(negedge clk);
    chk("b2b_wr_rdy", hready[0], 1);
    chk("b2b_wr_req", ram_req[0], 1);
    chk("b2b_wr_we", ram_we[0], 1);
    chk("b2b_wr_addr", ram_addr[0], 14'h8);
    chk("b2b_wr_data", ram_wdata[0], 32'hCAFEF00D);
    @(posedge clk); #1;
    htrans[0] = 2'd1;
    @(negedge clk);
    chk("b2b_rd_wait", hready[0], 0);
    chk("b2b_rd_req", ram_req[0], 1);
    chk("b2b_rd_we", ram_we[0], 0);
    @(posedge clk); #1;
    htrans[0] = 2'd0;
    @(negedge clk);
    chk("b2b_rd_rdy", hready[0], 1);
    chk("b2b_rd_data", hrdata[0], 32'hCAFEF00D);
    chk("b2b_rd_rsp", hresp[0], 0);
    @(posedge clk); #1;
    htrans[0] = 2'd1;
    @(negedge clk);
    chk("b2b_busy_rdy", hready[0], 1);
    chk("b2b_busy_rsp", hresp[0], 0);
    chk("b2b_busy_req", ram_req[0], 0);
    @(posedge clk); #1;
    hsel[0]   = 1'b0;
    htrans[0] = 2'd0;

    xfer(1, 32'h0048_0100, 3'd2, 1'b0, 0, r);
    chk("ws3_waits", r.waits, 4);
    chk("ws3_nreq", r.nreq, 1);
    chk("ws3_req_at", r.req_at, 4);
    chk("ws3_rsp", r.rsp, 0);

    for (int k = 0; k < 2; k++) begin
      ws = (k == 0) ? 0 : 3;
      mdl.delete();
      for (int n = 0; n < 60; n++) begin
        repeat ($urandom_range(0, 2)) idle_cyc(k);
        a  = (($urandom_range(0, 7) == 0) ? 32'h0049_1000 : 32'h0048_1000)
           + 32'($urandom_range(0, 63));
        sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        wr = 1'($urandom);
        wd = $urandom;
        e  = is_err(a, sz);
        xfer(k, a, sz, wr, wd, r);
        chk("rnd_rsp", r.rsp, e);
        chk("rnd_waits", r.waits, e ? 1 : (wr ? ws : ws + 1));
        chk("rnd_nreq", r.nreq, e ? 0 : 1);
        if (!e) begin
          nb     = 1 << sz;
          exp_be = '0;
          for (int i = 0; i < nb; i++) begin
            ba = a + 32'(i);
            exp_be[ba[1:0]] = 1'b1;
            if (wr) mdl[int'(ba[15:0])] = wd[8*ba[1:0] +: 8];
          end
          chk("rnd_be", r.be, exp_be);
          chk("rnd_addr", r.ra, a[15:2]);
          chk("rnd_req_at", r.req_at, ws + 1);
          if (!wr) begin
            wa     = {16'h0, a[15:2], 2'b00};
            exp_rd = '0;
            for (int i = 0; i < 4; i++)
              if (mdl.exists(int'(wa) + i))
                exp_rd[8*i +: 8] = mdl[int'(wa) + i];
            chk("rnd_rdata", r.rd, exp_rd);
          end
        end
      end
    end

    hsel[2]   = 1'b1;
    htrans[2] = 2'd2;
    haddr[2]  = 32'h0048_0040;
    hsize[2]  = 3'd2;
    hwrite[2] = 1'b0;
    @(posedge clk); #1;
    hsel[2]   = 1'b0;
    htrans[2] = 2'd0;
    @(negedge clk);
    chk("mid_wait1", hready[2], 0);
    @(posedge clk); #3;
    rst_n[2] = 1'b0;
    #1;
    chk("mid_rst_rdy", hready[2], 1);
    chk("mid_rst_rsp", hresp[2], 0);
    chk("mid_rst_req", ram_req[2], 0);
    @(negedge clk);
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    xfer(2, 32'h0048_0040, 3'd2, 1'b1, 32'h0BAD_CAFE, r);
    chk("post_wr_waits", r.waits, 5);
    chk("post_wr_rsp", r.rsp, 0);
    xfer(2, 32'h0048_0040, 3'd2, 1'b0, 0, r);
    chk("post_rd_waits", r.waits, 6);
    chk("post_rd_data", r.rd, 32'h0BAD_CAFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scr1_ahb_sram_slave.md
Name: scr1_ahb_sram_slave

Overview:
- AHB-Lite responder (subordinate) that terminates one SCR1 core AHB port, either imem or dmem, on a single-port synchronous SRAM.
- It is the other end of the core's AHB initiator ports. It replaces the behavioural memory model with synthesizable RTL for TCM/SRAM regions.
- Supports byte, half and word transfers, a programmable number of wait states, and the two-cycle ERROR response for illegal accesses.

Parameters:
- MEM_AW, 16, byte-address width of the SRAM window (window size 2**MEM_AW bytes, legal range 4..24).
- BASE_ADDR, 32'h0048_0000, window base; must be aligned to 2**MEM_AW.
- WAIT_STATES, 0, extra data-phase wait cycles inserted before the SRAM access (legal range 0..15).

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- hsel  input  1  slave select.
- htrans  input  2  AHB transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hsize  input  3  transfer size.
- hwrite  input  1  1=write.
- haddr  input  32  byte address.
- hwdata  input  32  write data (valid in data phase).
- hready  output  1  transfer-done / address-accept.
- hrdata  output  32  read data.
- hresp  output  1  0=OKAY, 1=ERROR.
- ram_req  output  1  SRAM access strobe.
- ram_we  output  1  SRAM write enable.
- ram_addr  output  MEM_AW-2  SRAM word address.
- ram_be  output  4  SRAM byte enables.
- ram_wdata  output  32  SRAM write data.
- ram_rdata  input  32  SRAM read data, valid the cycle after ram_req with ram_we=0.

Behaviour:
- Clock, reset and single-slave hready:
  - Single clock clk.
  - Asynchronous active-low reset rst_n.
  - hready is the only ready; there is no hready input.
- Reset values: state=IDLE, hready=1, hresp=0, hrdata=0, ram_req=0, ram_we=0, ram_be=0, wait counter=0.
- Address phase accept: when hready=1 && hsel && htrans[1]=1, register haddr, hsize and hwrite.
- Error check at accept: the access is illegal if any of the following holds:
  - hsize>2.
  - hsize=1 && haddr[0]=1.
  - hsize=2 && haddr[1:0]!=0.
  - haddr[31:MEM_AW]!=BASE_ADDR[31:MEM_AW].
- No-op transfers: hsel=0, IDLE or BUSY transfers get a zero-wait OKAY; state stays IDLE.
- FSM states:
  - IDLE: hready=1. Legal accept -> DPH, with the counter loaded to WAIT_STATES. Illegal accept -> ERR1.
  - DPH: while counter>0, hready=0 and decrement. At counter=0, drive ram_req=1, ram_addr=addr[MEM_AW-1:2] and ram_be.
    - Write: ram_we=1, ram_wdata=hwdata, hready=1, hresp=0. A new address may be accepted this cycle (back-to-back); next state follows the IDLE accept rules.
    - Read: ram_we=0, hready=0 -> RD.
  - RD: hrdata=ram_rdata, hready=1, hresp=0. Accepts a new address this cycle, same rules as IDLE.
  - ERR1: hready=0, hresp=1, no ram_req -> ERR2.
  - ERR2: hready=1, hresp=1. Accepts a new address this cycle (AHB allows it; the master is expected to issue IDLE).
- ram_be rules:
  - byte: 4'b0001<<addr[1:0].
  - half: 4'b0011<<{addr[1],1'b0}.
  - word: 4'hF.
- Read data lanes: reads return the full word. The master selects lanes per little-endian AHB.
- Latency: writes take WAIT_STATES wait cycles; reads take WAIT_STATES+1.
- hrdata outside RD: 0.
- hresp: 1 only in ERR1 and ERR2.
- Illegal accesses never assert ram_req.
- Reset mid-transfer: immediately return to IDLE with reset outputs. A pending SRAM write is dropped.
- hsel/htrans during wait states: ignored. Address and control are sampled only when hready=1.

Test Plan:
- Zero-wait write then read (WAIT_STATES=0):
  - Stimulus: NONSEQ word write 0x0048_0010 with data 0xDEADBEEF, then a read of the same address.
  - Required: write data phase hready=1, ram_be=F, ram_addr=0x4. Read sees 1 wait cycle, then hrdata=0xDEADBEEF, hresp=0.
- Sub-word writes (WAIT_STATES=0):
  - Stimulus: byte write 0x55 to 0x0048_0003, then half-word write 0x1234 to 0x0048_0002.
  - Required: ram_be=4'b1000, then 4'b1100. A word read returns 0x1234xxxx in the upper lanes.
- Wait states (WAIT_STATES=3):
  - Stimulus: word read.
  - Required: hready low for exactly 4 cycles; ram_req pulses once, on the 4th low cycle.
- Error cases:
  - Stimulus: word read at 0x0048_0002 (misaligned), then a read at 0x0049_0000 (out of window, MEM_AW=16).
  - Required: each gets ERR1 (hready=0, hresp=1) then ERR2 (hready=1, hresp=1); ram_req stays 0.
- Back-to-back pipelining:
  - Stimulus: NONSEQ write to A, then SEQ read of A presented in the write's data phase; IDLE and BUSY cycles interleaved.
  - Required: the read is accepted with no bubble and returns the new data. IDLE/BUSY get OKAY with hready=1.
- Reset mid-read (WAIT_STATES=5):
  - Stimulus: assert rst_n=0 during the 2nd wait cycle.
  - Required: hready=1, hresp=0, ram_req=0 asynchronously. After release, the next transfer completes normally.
